seg7_to_bcd_decoder: RTL and testbench



---
 rtl/seg7_to_bcd_decoder.sv | 145 ++++++++++++++
 tb/tb_seg7_to_bcd_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_to_bcd_decoder.sv
// Recovers BCD digits from an active-low 7-segment drive: synchronize, debounce,
// decode each newly stable pattern and hand it off on a single-entry valid/ready port.
module seg7_to_bcd_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DROP_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        seg_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [3:0]        bcd_out,
  output logic              out_err,
  output logic              blank,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [6:0]        SEG_BLANK = 7'h7F;
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Returns {invalid, bcd}; any non-digit pattern maps to {1, 4'hF}.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b0000001: res = 5'b0_0000;
      7'b1001111: res = 5'b0_0001;
      7'b0010010: res = 5'b0_0010;
      7'b0000110: res = 5'b0_0011;
      7'b1001100: res = 5'b0_0100;
      7'b0100100: res = 5'b0_0101;
      7'b0100000: res = 5'b0_0110;
      7'b0001111: res = 5'b0_0111;
      7'b0000000: res = 5'b0_1000;
      7'b0000100: res = 5'b0_1001;
      default:    res = 5'b1_1111;
    endcase
    return res;
  endfunction

  logic [6:0]       sync1_r, sync2_r, cand_r, last_r;
  logic [CNT_W-1:0] cnt_r;
  state_t           state_r;

  logic       stable_s, fire_s, is_blank_s, out_ev_s;
  logic [4:0] dec_s;

  // Event fires once per pattern that has stayed stable long enough and differs from the last one.
  always_comb begin
    stable_s   = (sync2_r == cand_r);
    is_blank_s = (cand_r == SEG_BLANK);
    fire_s     = stable_s && (cnt_r == CNT_MAX) && (cand_r != last_r);
    out_ev_s   = fire_s && !is_blank_s;
    dec_s      = decode_seg(cand_r);
  end

  // Synchronizer and stability filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= SEG_BLANK;
      sync2_r <= SEG_BLANK;
      cand_r  <= SEG_BLANK;
      last_r  <= SEG_BLANK;
      cnt_r   <= '0;
    end else begin
      sync1_r <= seg_in;
      sync2_r <= sync1_r;
      if (!stable_s) begin
        cand_r <= sync2_r;
        cnt_r  <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (fire_s) begin
        last_r <= cand_r;
      end else begin
        last_r <= last_r;
      end
    end
  end

  // Single-entry output holding register with saturating drop count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      bcd_out   <= 4'h0;
      out_err   <= 1'b0;
      blank     <= 1'b1;
      drop_cnt  <= '0;
    end else begin
      if (fire_s) begin
        blank <= is_blank_s;
      end else begin
        blank <= blank;
      end
      case (state_r)
        IDLE: begin
          if (out_ev_s) begin
            state_r   <= HOLD;
            out_valid <= 1'b1;
            bcd_out   <= dec_s[3:0];
            out_err   <= dec_s[4];
          end else begin
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (out_ev_s) begin
              bcd_out <= dec_s[3:0];
              out_err <= dec_s[4];
            end else begin
              state_r   <= IDLE;
              out_valid <= 1'b0;
            end
          end else if (out_ev_s) begin
            if (drop_cnt != DROP_MAX) begin
              drop_cnt <= drop_cnt + DROP_ONE;
            end else begin
              drop_cnt <= drop_cnt;
            end
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_to_bcd_decoder.sv
// Randomized scoreboard bench for seg7_to_bcd_decoder: a run-length reference model
// predicts events, a monitor checks them against the DUT handshake.
module tb_seg7_to_bcd_decoder;
  localparam int S  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    seg_in = 7'h7F;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [3:0]    bcd_out;
  logic          out_err;
  logic          blank;
  logic [DW-1:0] drop_cnt;

  always #5 clk = ~clk;

  seg7_to_bcd_decoder #(.STABLE_CYCLES(S), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .out_ready(out_ready),
    .out_valid(out_valid), .bcd_out(bcd_out), .out_err(out_err),
    .blank(blank), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  logic [6:0] digit_pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // reference model state
  logic [6:0] m_prev, m_last;
  int         m_run, m_drop;
  logic       m_blank, m_hold;
  logic       pend_v [2];
  logic [6:0] pend_p [2];
  logic [4:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0..9 digit, 10 blank, -1 undecodable
  function automatic int lookup(input logic [6:0] p);
    if (p == 7'h7F) return 10;
    for (int i = 0; i < 10; i++) if (digit_pat[i] == p) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_prev = 7'h7F; m_run = 100; m_last = 7'h7F;
    m_blank = 1'b1; m_hold = 1'b0; m_drop = 0;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    pend_p[0] = 7'h7F; pend_p[1] = 7'h7F;
    exp_q.delete();
  endfunction

  // A pattern sampled for S+1 consecutive edges becomes an event two edges later.
  function automatic void model_step();
    logic       fv, ev;
    logic [6:0] fp;
    logic [4:0] code;
    int         d;
    fv = pend_v[1]; fp = pend_p[1];
    pend_v[1] = pend_v[0]; pend_p[1] = pend_p[0];
    if (seg_in == m_prev) begin
      if (m_run < 100) m_run++;
    end else begin
      m_prev = seg_in; m_run = 1;
    end
    pend_v[0] = (m_run == S + 1);
    pend_p[0] = m_prev;
    ev = 1'b0; code = 5'h00;
    if (fv && fp != m_last) begin
      m_last = fp;
      d = lookup(fp);
      if (d == 10) m_blank = 1'b1;
      else begin
        m_blank = 1'b0; ev = 1'b1;
        code = (d < 0) ? 5'h1F : {1'b0, 4'(d)};
      end
    end
    if (!m_hold) begin
      if (ev) begin m_hold = 1'b1; exp_q.push_back(code); end
    end else if (out_ready) begin
      if (ev) exp_q.push_back(code);
      else m_hold = 1'b0;
    end else if (ev) begin
      if (m_drop < 255) m_drop++;
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // monitor: sample mid-cycle, pop on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("blank", 32'(blank), 32'(m_blank));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (out_valid && m_hold) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL queue_empty: got valid output %0h with no expected event", bcd_out);
          end else begin
            chk("event_data", 32'({out_err, bcd_out}), 32'(exp_q[0]));
            if (out_ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
            end
          end
        end
      end
    end
  end

  // drive one sampled cycle per iteration; mode 0/1 = ready constant, 2 = random
  task automatic hold(input logic [6:0] p, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      seg_in = p;
      out_ready = (mode == 2) ? ($urandom_range(0, 9) < 7) : (mode == 1);
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int first;
    int r;
    logic [6:0] p;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // digit 0 latency and single firing
    seg_in = digit_pat[0]; out_ready = 1'b1; first = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (out_valid && first == 0) first = e;
      #1;
    end
    chk("latency", 32'(first), 32'd7);
    hold(digit_pat[0], 6, 1);
    chk("single_event", 32'(hs_cnt), 32'd1);

    // short 5 then blank: filtered
    hold(digit_pat[5], 3, 1);
    hold(7'h7F, 8, 1);
    chk("short_no_event", 32'(hs_cnt), 32'd1);
    chk("short_blank", 32'(blank), 32'd1);
    chk("short_drop", 32'(drop_cnt), 32'd0);

    // undecodable pattern
    hold(7'b1111110, 8, 1);
    chk("invalid_event", 32'(hs_cnt), 32'd2);

    // back-pressure: 3 held, 7 dropped
    hold(digit_pat[3], 8, 0);
    hold(digit_pat[7], 8, 0);
    chk("drop_one", 32'(drop_cnt), 32'd1);
    chk("held_digit", 32'({out_valid, bcd_out}), 32'h13);
    hold(digit_pat[7], 1, 1);
    chk("accept_idle", 32'(out_valid), 32'd0);

    // 2, blank, 2 fires twice
    hold(digit_pat[2], 6, 1);
    hold(7'h7F, 6, 1);
    hold(digit_pat[2], 6, 1);
    hold(digit_pat[2], 4, 1);
    chk("repeat_after_blank", 32'(hs_cnt), 32'd5);
    chk("blank_cleared", 32'(blank), 32'd0);

    // new event on the accept edge replaces held data without a drop
    hold(digit_pat[4], 8, 0);
    hold(digit_pat[9], 6, 0);
    hold(digit_pat[9], 1, 1);
    chk("replace_valid_bcd", 32'({out_valid, bcd_out}), 32'h19);
    chk("replace_no_drop", 32'(drop_cnt), 32'd1);
    hold(digit_pat[9], 3, 1);

    // randomized traffic
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55) p = digit_pat[$urandom_range(0, 9)];
      else if (r < 70) p = 7'h7F;
      else p = 7'($urandom);
      hold(p, $urandom_range(1, 8), 2);
    end

    // reset during HOLD
    hold(digit_pat[1], 8, 0);
    hold(digit_pat[6], 8, 0);
    hold(digit_pat[8], 8, 0);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_blank", 32'(blank), 32'd1);
    chk("reset_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk); #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
